serial_rx_sequencer: RTL

//  Master controller for the serial-in/parallel-out receive path. Detects the start bit,

---
 rtl/serial_pkg.sv | 23 ++
 rtl/serial_rx_sequencer_if.sv | 38 +++
 rtl/rx_bit_timer.sv | 60 ++++++
 rtl/serial_rx_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared serial-frame definitions for the receive (and transmit) paths.
//   rx_state_e    : receive sequencer states
//   *_DEF         : default frame timing/shape constants
//   bsc_width()   : width of a counter that spans 0..spb-1 (never zero)
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int   SPB_DEF         = 16;
  localparam int   MID_DEF         = 8;
  localparam int   DATA_BITS_DEF   = 8;
  localparam logic START_LEVEL_DEF = 1'b1;

  function automatic int bsc_width(input int spb);
    return (spb > 1) ? $clog2(spb) : 1;
  endfunction

endpackage

// File: rtl/serial_rx_sequencer_if.sv
// Bundle between the receive sequencer and its environment.
//   bitStream  : synchronised serial line (into sequencer)
//   rx_ready   : consumer accepts rx_data while rx_valid=1 (into sequencer)
//   rx_data    : received byte, stable while rx_valid=1
//   rx_valid   : byte available
//   frame_err  : stop bit was wrong for the byte in rx_data
//   overrun    : one-cycle pulse, a completed byte was dropped
//   busy       : sequencer is inside a frame
//   BSC / BIC  : bit sample counter / bit index, exported for the SIPO datapath
// Modport master is the sequencer side; slave is the line/consumer side.
interface serial_rx_sequencer_if
  import serial_pkg::*;
#(
  parameter int SPB       = SPB_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
);
  localparam int BSC_W = bsc_width(SPB);

  logic                 bitStream;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
  logic [BSC_W-1:0]     BSC;
  logic [3:0]           BIC;

  modport master (
    input  bitStream, rx_ready,
    output rx_data, rx_valid, frame_err, overrun, busy, BSC, BIC
  );

  modport slave (
    output bitStream, rx_ready,
    input  rx_data, rx_valid, frame_err, overrun, busy, BSC, BIC
  );
endinterface

// File: rtl/rx_bit_timer.sv
// Bit timing for the receive sequencer.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : zero both counters (wins over en_i)
//   en_i     : advance BSC; on wrap from SPB-1 to 0, advance BIC
//   bsc_o    : bit sample counter, 0..SPB-1
//   bic_o    : bit index
//   mid_o    : BSC is at the mid-bit sample point
//   last_o   : BSC is at the final sample of the bit
module rx_bit_timer #(
  parameter int SPB   = 16,
  parameter int MID   = 8,
  parameter int BSC_W = 4,
  parameter int BIC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [BSC_W-1:0] bsc_o,
  output logic [BIC_W-1:0] bic_o,
  output logic             mid_o,
  output logic             last_o
);
  localparam logic [BSC_W-1:0] MID_C  = BSC_W'(MID);
  localparam logic [BSC_W-1:0] LAST_C = BSC_W'(SPB - 1);

  logic [BSC_W-1:0] bsc_q, bsc_d;
  logic [BIC_W-1:0] bic_q, bic_d;

  always_comb begin
    bsc_d = bsc_q;
    bic_d = bic_q;
    if (clr_i) begin
      bsc_d = '0;
      bic_d = '0;
    end else if (en_i) begin
      if (bsc_q == LAST_C) begin
        bsc_d = '0;
        bic_d = bic_q + BIC_W'(1);
      end else begin
        bsc_d = bsc_q + BSC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bsc_q <= '0;
      bic_q <= '0;
    end else begin
      bsc_q <= bsc_d;
      bic_q <= bic_d;
    end
  end

  assign bsc_o  = bsc_q;
  assign bic_o  = bic_q;
  assign mid_o  = (bsc_q == MID_C);
  assign last_o = (bsc_q == LAST_C);
endmodule

// File: rtl/serial_rx_sequencer.sv
// Receive sequencer: detects the start bit, times each bit with rx_bit_timer,
// samples at mid-bit, assembles the word LSB first and hands it out through
// a valid/ready register with frame-error and overrun flags.
//   clk, rst : clock, asynchronous active-high reset
//   rx_if    : line input, consumer handshake and status (master side)
module serial_rx_sequencer
  import serial_pkg::*;
#(
  parameter int   SPB         = SPB_DEF,
  parameter int   MID         = MID_DEF,
  parameter int   DATA_BITS   = DATA_BITS_DEF,
  parameter logic START_LEVEL = START_LEVEL_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_rx_sequencer_if.master  rx_if
);
  localparam int         BSC_W     = bsc_width(SPB);
  localparam logic [3:0] BIC_LASTD = 4'(DATA_BITS);

  rx_state_e state_q, state_d;

  logic [BSC_W-1:0]     bsc;
  logic [3:0]           bic;
  logic                 at_mid, at_last;
  logic                 timer_clr, timer_en;
  logic                 line_start, commit;

  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  assign line_start = (rx_if.bitStream == START_LEVEL);

  rx_bit_timer #(
    .SPB   (SPB),
    .MID   (MID),
    .BSC_W (BSC_W),
    .BIC_W (4)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (timer_clr),
    .en_i   (timer_en),
    .bsc_o  (bsc),
    .bic_o  (bic),
    .mid_o  (at_mid),
    .last_o (at_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (line_start) state_d = START;
      START: begin
        if (at_mid && !line_start) state_d = IDLE;   // false start
        else if (at_last)          state_d = DATA;
      end
      DATA:  if (at_last && (bic == BIC_LASTD)) state_d = STOP;
      STOP:  if (at_mid) state_d = IDLE;             // leave half a bit early to resync
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    // Clearing on the way into IDLE keeps BSC/BIC at 0 for every IDLE cycle.
    timer_clr   = (state_q == IDLE) || (state_d == IDLE);
    timer_en    = (state_q != IDLE);
    commit      = (state_q == STOP) && at_mid;

    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = 1'b0;
    busy_d      = (state_d != IDLE);

    if ((state_q == DATA) && at_mid) begin
      shift_d = shift_q >> 1;
      shift_d[DATA_BITS-1] = rx_if.bitStream;
    end

    if (commit) begin
      // A pending byte accepted in this same cycle makes room for the new one.
      if (!rx_valid_q || rx_if.rx_ready) begin
        rx_data_d   = shift_q;
        frame_err_d = line_start;
        rx_valid_d  = 1'b1;
      end else begin
        overrun_d   = 1'b1;
      end
    end else if (rx_valid_q && rx_if.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overrun   = overrun_q;
  assign rx_if.busy      = busy_q;
  assign rx_if.BSC       = bsc;
  assign rx_if.BIC       = bic;
endmodule
